chdr_pkt_gen: RTL and testbench



---
 rtl/chdr_pkt_gen.sv | 244 ++++++++++++++++++++++++
 tb/tb_chdr_pkt_gen.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chdr_pkt_gen.sv
// chdr_pkt_gen: round-robin CHDR packet source, configured over the settings bus.
// Define CHDR_PKT_GEN_TIMESTAMP_EN to add has_time headers followed by a TIME line.
module chdr_pkt_gen #(
  parameter int BASE        = 0,
  parameter int NUM_STREAMS = 4,
  parameter int SR_AWIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 set_stb,
  input  logic [SR_AWIDTH-1:0] set_addr,
  input  logic [31:0]          set_data,
  output logic [63:0]          o_tdata,
  output logic                 o_tlast,
  output logic                 o_tvalid,
  input  logic                 o_tready,
  output logic                 busy,
  output logic [31:0]          pkts_sent
);

  localparam logic [SR_AWIDTH-1:0] BASE_A      = SR_AWIDTH'(BASE);
  localparam logic [SR_AWIDTH-1:0] OFF_CTRL    = SR_AWIDTH'(0);
  localparam logic [SR_AWIDTH-1:0] OFF_NUM     = SR_AWIDTH'(1);
  localparam logic [SR_AWIDTH-1:0] OFF_LEN     = SR_AWIDTH'(2);
  localparam logic [SR_AWIDTH-1:0] OFF_GAP     = SR_AWIDTH'(3);
  localparam logic [SR_AWIDTH-1:0] OFF_SID     = SR_AWIDTH'(4);
  localparam logic [SR_AWIDTH-1:0] OFF_SID_END = SR_AWIDTH'(4 + NUM_STREAMS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
`ifdef CHDR_PKT_GEN_TIMESTAMP_EN
    S_TIME,
`endif
    S_PAYLOAD,
    S_GAP
  } state_t;

  state_t                 state, state_nxt;
  logic                   ctrl_en, ctrl_cont, clear_pend;
  logic [31:0]            num_pkts;
  logic [11:0]            payload_len;
  logic [15:0]            gap;
  logic [31:0]            sid [16];
  logic [11:0]            seq [16];
  logic [3:0]             k;
  logic [11:0]            idx, len_lat;
  logic [15:0]            gap_cnt;
  logic [SR_AWIDTH-1:0]   off;
  logic [3:0]             sid_idx;

  logic                   hs, tlast_hs, do_clear, go, start, stop;
  logic [3:0]             k_inc, k_after;
  logic [11:0]            seq_inc, seq_after, len_eff, idx_nxt, len_nxt;
  logic [31:0]            pkts_inc, pkts_after;
  logic [63:0]            hdr_line, pay0_line, tdata_nxt;
  logic                   tlast_nxt, tvalid_nxt;
  logic [15:0]            gap_nxt;

`ifdef CHDR_PKT_GEN_TIMESTAMP_EN
  logic [63:0]            cyc_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc_cnt <= '0;
    else          cyc_cnt <= cyc_cnt + 64'd1;
  end
`endif

  function automatic logic [63:0] make_hdr(input logic [11:0] sq, input logic [11:0] ln,
                                           input logic [31:0] sid_v);
    logic [15:0] bytes;
    bytes = {1'b0, ln, 3'b000} + 16'd8;
`ifdef CHDR_PKT_GEN_TIMESTAMP_EN
    return {4'b0010, sq, bytes + 16'd8, sid_v};
`else
    return {4'b0000, sq, bytes, sid_v};
`endif
  endfunction

  // Payload: stream index in the top byte, seqnum in [43:32], line index in [31:0].
  function automatic logic [63:0] make_pay(input logic [3:0] kk, input logic [11:0] sq,
                                           input logic [11:0] i);
    return {4'h0, kk, 12'h000, sq, 20'h00000, i};
  endfunction

  assign off     = set_addr - BASE_A;
  assign sid_idx = 4'(off - OFF_SID);
  assign busy    = (state != S_IDLE);

  always_comb begin
    hs        = o_tvalid & o_tready;
    tlast_hs  = hs & o_tlast;
    do_clear  = clear_pend & (tlast_hs | (state == S_IDLE) | (state == S_GAP));
    k_inc     = (k == 4'(NUM_STREAMS - 1)) ? 4'd0 : k + 4'd1;
    seq_inc   = seq[k] + 12'd1;
    pkts_inc  = (&pkts_sent) ? pkts_sent : pkts_sent + 32'd1;
    // Counter values as they will stand after this cycle; the next header is built from these.
    k_after    = k;
    pkts_after = pkts_sent;
    seq_after  = seq[k];
    if (do_clear) begin
      k_after    = 4'd0;
      pkts_after = 32'd0;
      seq_after  = 12'd0;
    end else if (tlast_hs) begin
      k_after    = k_inc;
      pkts_after = pkts_inc;
      seq_after  = (k_inc == k) ? seq_inc : seq[k_inc];
    end
    go        = ctrl_en & (ctrl_cont | (pkts_after < num_pkts));
    len_eff   = (payload_len == 12'd0) ? 12'd1 : payload_len;
    hdr_line  = make_hdr(seq_after, len_eff, sid[k_after]);
    pay0_line = make_pay(k, seq[k], 12'd0);

    state_nxt  = state;
    tdata_nxt  = o_tdata;
    tlast_nxt  = o_tlast;
    tvalid_nxt = o_tvalid;
    idx_nxt    = idx;
    gap_nxt    = gap_cnt;
    len_nxt    = len_lat;
    start      = 1'b0;
    stop       = 1'b0;
    case (state)
      S_IDLE: start = go;
      S_HDR: if (hs) begin
`ifdef CHDR_PKT_GEN_TIMESTAMP_EN
        state_nxt = S_TIME;
        tdata_nxt = cyc_cnt;
`else
        state_nxt = S_PAYLOAD;
        tdata_nxt = pay0_line;
        tlast_nxt = (len_lat == 12'd1);
        idx_nxt   = 12'd0;
`endif
      end
`ifdef CHDR_PKT_GEN_TIMESTAMP_EN
      S_TIME: if (hs) begin
        state_nxt = S_PAYLOAD;
        tdata_nxt = pay0_line;
        tlast_nxt = (len_lat == 12'd1);
        idx_nxt   = 12'd0;
      end
`endif
      S_PAYLOAD: if (hs) begin
        if (o_tlast) begin
          if (gap != 16'd0) begin
            state_nxt  = S_GAP;
            gap_nxt    = gap;
            tvalid_nxt = 1'b0;
            tlast_nxt  = 1'b0;
            tdata_nxt  = '0;
          end else if (go) begin
            start = 1'b1;
          end else begin
            stop = 1'b1;
          end
        end else begin
          idx_nxt   = idx + 12'd1;
          tdata_nxt = make_pay(k, seq[k], idx + 12'd1);
          tlast_nxt = (idx + 12'd2 == len_lat);
        end
      end
      S_GAP: begin
        if (gap_cnt <= 16'd1) begin
          start = go;
          stop  = ~go;
        end else begin
          gap_nxt = gap_cnt - 16'd1;
        end
      end
      default: stop = 1'b1;
    endcase
    if (start) begin
      state_nxt  = S_HDR;
      tdata_nxt  = hdr_line;
      tvalid_nxt = 1'b1;
      tlast_nxt  = 1'b0;
      len_nxt    = len_eff;
    end
    if (stop) begin
      state_nxt  = S_IDLE;
      tdata_nxt  = '0;
      tvalid_nxt = 1'b0;
      tlast_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en     <= 1'b0;
      ctrl_cont   <= 1'b0;
      clear_pend  <= 1'b0;
      num_pkts    <= '0;
      payload_len <= '0;
      gap         <= '0;
      for (int i = 0; i < 16; i++) sid[i] <= '0;
    end else begin
      if (set_stb) begin
        if (off == OFF_CTRL) begin
          ctrl_en   <= set_data[0];
          ctrl_cont <= set_data[1];
        end
        if (off == OFF_NUM) num_pkts <= set_data;
        if (off == OFF_LEN) payload_len <= set_data[11:0];
        if (off == OFF_GAP) gap <= set_data[15:0];
        if (off >= OFF_SID && off < OFF_SID_END) sid[sid_idx] <= set_data;
      end
      if (set_stb && off == OFF_CTRL && set_data[2]) clear_pend <= 1'b1;
      else if (do_clear)                             clear_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      o_tdata   <= '0;
      o_tlast   <= 1'b0;
      o_tvalid  <= 1'b0;
      idx       <= '0;
      gap_cnt   <= '0;
      len_lat   <= '0;
      k         <= '0;
      pkts_sent <= '0;
      for (int i = 0; i < 16; i++) seq[i] <= '0;
    end else begin
      state     <= state_nxt;
      o_tdata   <= tdata_nxt;
      o_tlast   <= tlast_nxt;
      o_tvalid  <= tvalid_nxt;
      idx       <= idx_nxt;
      gap_cnt   <= gap_nxt;
      len_lat   <= len_nxt;
      k         <= k_after;
      pkts_sent <= pkts_after;
      if (do_clear) begin
        for (int i = 0; i < 16; i++) seq[i] <= '0;
      end else if (tlast_hs) begin
        seq[k] <= seq_inc;
      end
    end
  end

endmodule

// File: tb/tb_chdr_pkt_gen.sv
// Directed bench for chdr_pkt_gen: packet contents, stalls, gaps, disable, reset, seq wrap.
module tb_chdr_pkt_gen;
`ifdef CHDR_PKT_GEN_TIMESTAMP_EN
  localparam int TS = 1;
`else
  localparam int TS = 0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = '0;
  logic [31:0] set_data = '0;
  logic [63:0] o_tdata;
  logic        o_tlast, o_tvalid, busy;
  logic        o_tready = 1'b1;
  logic [31:0] pkts_sent;

  logic        c_set_stb = 1'b0;
  logic [7:0]  c_set_addr = '0;
  logic [31:0] c_set_data = '0;
  logic [63:0] c_tdata;
  logic        c_tlast, c_tvalid, c_busy;
  logic [31:0] c_pkts_sent;

  chdr_pkt_gen #(.BASE(0), .NUM_STREAMS(4), .SR_AWIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .busy(busy), .pkts_sent(pkts_sent));

  chdr_pkt_gen #(.BASE(0), .NUM_STREAMS(1), .SR_AWIDTH(8)) dut1 (
    .clk(clk), .reset_n(reset_n), .set_stb(c_set_stb), .set_addr(c_set_addr), .set_data(c_set_data),
    .o_tdata(c_tdata), .o_tlast(c_tlast), .o_tvalid(c_tvalid), .o_tready(1'b1),
    .busy(c_busy), .pkts_sent(c_pkts_sent));

  typedef struct { logic [63:0] data; logic last; int cyc; } line_t;
  typedef struct { int k; int seq; logic [63:0] hdr; } pk_t;

  line_t cap[$];
  line_t c_cap[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;
  bit    rand_rdy = 1'b0;
  logic [63:0] hold_data;
  logic        hold_last;
  bit          hold_pend = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rand_rdy) o_tready = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Lines are recorded at the falling edge if they will be accepted at the next rising edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (hold_pend) chk("stall_hold", {o_tvalid, o_tlast, o_tdata}, {1'b1, hold_last, hold_data});
      hold_pend = o_tvalid && !o_tready;
      hold_data = o_tdata;
      hold_last = o_tlast;
      if (o_tvalid && o_tready) cap.push_back('{o_tdata, o_tlast, cyc});
      if (c_tvalid) c_cap.push_back('{c_tdata, c_tlast, cyc});
    end else begin
      hold_pend = 1'b0;
    end
  end

  function automatic logic [63:0] mk_hdr(input int seq, input logic [31:0] sid, input int plen);
    int pl;
    pl = (plen == 0) ? 1 : plen;
    return {2'b00, 1'(TS), 1'b0, 12'(seq), 16'(pl * 8 + 8 + TS * 8), sid};
  endfunction

  function automatic logic [63:0] mk_pay(input int k, input int seq, input int i);
    return {8'(k), 12'h000, 12'(seq), 32'(i)};
  endfunction

  task automatic wr(input bit sel, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    if (sel) begin c_set_stb = 1'b1; c_set_addr = a; c_set_data = d; end
    else     begin set_stb = 1'b1;   set_addr = a;   set_data = d;   end
    @(negedge clk);
    set_stb = 1'b0;
    c_set_stb = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < bound) begin @(negedge clk); n++; end
    chk(name, busy, 1'b0);
  endtask

  task automatic check_pkt(input int st, input logic [63:0] hdr, input int k, input int seq,
                           input int plen, input string tag);
    int    n, bad;
    line_t l;
    n = 1 + TS + plen;
    bad = 0;
    if (cap.size() < st + n) begin
      chk({tag, "_size"}, cap.size(), st + n);
      return;
    end
    chk({tag, "_hdr"}, {cap[st].last, cap[st].data}, {1'b0, hdr});
    for (int i = 0; i < plen; i++) begin
      l = cap[st + 1 + TS + i];
      if (l.data !== mk_pay(k, seq, i) || l.last !== (i == plen - 1)) bad++;
    end
    chk({tag, "_payload_bad_lines"}, bad, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    pk_t   t1[7];
    int    n, per, bad, nb;
    logic [63:0] ts_adj;
    ts_adj = (TS == 1) ? 64'h2000_0008_0000_0000 : 64'h0;
    t1[0] = '{k: 0, seq: 0, hdr: 64'h0000_07D8_0000_0001};
    t1[1] = '{k: 1, seq: 0, hdr: 64'h0000_07D8_0000_0002};
    t1[2] = '{k: 2, seq: 0, hdr: 64'h0000_07D8_0000_0003};
    t1[3] = '{k: 3, seq: 0, hdr: 64'h0000_07D8_0000_0004};
    t1[4] = '{k: 0, seq: 1, hdr: 64'h0001_07D8_0000_0001};
    t1[5] = '{k: 1, seq: 1, hdr: 64'h0001_07D8_0000_0002};
    t1[6] = '{k: 2, seq: 1, hdr: 64'h0001_07D8_0000_0003};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_tdata", o_tdata, 64'h0);
    chk("rst_tlast", o_tlast, 1'b0);
    chk("rst_tvalid", o_tvalid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pkts_sent", pkts_sent, 32'd0);
    reset_n = 1'b1;

    // Seven packets round-robin over four SIDs, latency and back-to-back throughput
    for (int i = 0; i < 4; i++) wr(1'b0, 8'(4 + i), 32'(i + 1));
    wr(1'b0, 8'd2, 32'd250);
    wr(1'b0, 8'd3, 32'd0);
    wr(1'b0, 8'd1, 32'd7);
    chk("idle_before_enable", o_tvalid, 1'b0);
    cap.delete();
    wr(1'b0, 8'd0, 32'd1);
    chk("lat_tvalid_low", o_tvalid, 1'b0);
    @(negedge clk);
    chk("lat_tvalid_high", o_tvalid, 1'b1);
    chk("busy_high", busy, 1'b1);
    wait_idle(2500, "run7_busy_falls");
    chk("run7_pkts_sent", pkts_sent, 32'd7);
    chk("run7_lines", cap.size(), 7 * (251 + TS));
    for (int p = 0; p < 7; p++)
      check_pkt(p * (251 + TS), t1[p].hdr | ts_adj, t1[p].k, t1[p].seq, 250, $sformatf("run7_p%0d", p));
    if (cap.size() == 7 * (251 + TS))
      chk("run7_no_bubbles", cap[cap.size() - 1].cyc - cap[0].cyc, 7 * (251 + TS) - 1);

    // Clear, then three short packets with random backpressure
    wr(1'b0, 8'd0, 32'd4);
    @(negedge clk);
    chk("clear_pkts_sent", pkts_sent, 32'd0);
    wr(1'b0, 8'd2, 32'd5);
    wr(1'b0, 8'd1, 32'd3);
    cap.delete();
    rand_rdy = 1'b1;
    wr(1'b0, 8'd0, 32'd1);
    wait_idle(600, "stall_busy_falls");
    rand_rdy = 1'b0;
    o_tready = 1'b1;
    chk("stall_lines", cap.size(), 3 * (6 + TS));
    for (int p = 0; p < 3; p++)
      check_pkt(p * (6 + TS), mk_hdr(0, 32'(p + 1), 5), p, 0, 5, $sformatf("stall_p%0d", p));
    chk("stall_pkts_sent", pkts_sent, 32'd3);

    // GAP=3 between two packets
    wr(1'b0, 8'd0, 32'd4);
    wr(1'b0, 8'd2, 32'd2);
    wr(1'b0, 8'd3, 32'd3);
    wr(1'b0, 8'd1, 32'd2);
    cap.delete();
    wr(1'b0, 8'd0, 32'd1);
    wait_idle(100, "gap_busy_falls");
    chk("gap_lines", cap.size(), 2 * (3 + TS));
    check_pkt(0, mk_hdr(0, 32'd1, 2), 0, 0, 2, "gap_p0");
    check_pkt(3 + TS, mk_hdr(0, 32'd2, 2), 1, 0, 2, "gap_p1");
    if (cap.size() == 2 * (3 + TS))
      chk("gap_cycles", cap[3 + TS].cyc - cap[2 + TS].cyc, 4);

    // Disable in the middle of a continuous run: the packet still completes
    wr(1'b0, 8'd0, 32'd4);
    wr(1'b0, 8'd3, 32'd0);
    wr(1'b0, 8'd2, 32'd250);
    cap.delete();
    wr(1'b0, 8'd0, 32'd3);
    n = 0;
    while (cap.size() < 11 + TS && n < 200) begin @(negedge clk); n++; end
    chk("dis_reached_line10", cap.size() >= 11 + TS, 1'b1);
    wr(1'b0, 8'd0, 32'd0);
    wait_idle(600, "dis_busy_falls");
    repeat (5) @(negedge clk);
    chk("dis_lines", cap.size(), 251 + TS);
    check_pkt(0, mk_hdr(0, 32'd1, 250), 0, 0, 250, "dis_p0");
    chk("dis_pkts_sent", pkts_sent, 32'd1);

    // Asynchronous reset in the middle of a packet
    wr(1'b0, 8'd0, 32'd1);
    repeat (20) @(negedge clk);
    chk("mid_tvalid_before_rst", o_tvalid, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_tvalid", o_tvalid, 1'b0);
    chk("arst_tlast_tdata", {o_tlast, o_tdata}, 65'h0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_pkts_sent", pkts_sent, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Continuous single-stream run across the 12-bit seqnum wrap
    per = 2 + TS;
    wr(1'b1, 8'd4, 32'hABCD_0000);
    wr(1'b1, 8'd2, 32'd1);
    c_cap.delete();
    wr(1'b1, 8'd0, 32'd3);
    n = 0;
    while (c_cap.size() < 4100 * per && n < 20000) begin @(negedge clk); n++; end
    wr(1'b1, 8'd0, 32'd0);
    n = 0;
    while (c_busy && n < 50) begin @(negedge clk); n++; end
    chk("cont_busy_falls", c_busy, 1'b0);
    chk("cont_enough_lines", c_cap.size() >= 4100 * per, 1'b1);
    if (c_cap.size() >= 4100 * per) begin
      bad = 0;
      nb = 0;
      for (int p = 0; p < 4100; p++) begin
        if (c_cap[p * per].data !== mk_hdr(p % 4096, 32'hABCD_0000, 1) || c_cap[p * per].last !== 1'b0) bad++;
        if (c_cap[p * per + per - 1].data !== mk_pay(0, p % 4096, 0) || c_cap[p * per + per - 1].last !== 1'b1) bad++;
      end
      for (int j = 1; j < 4100 * per; j++)
        if (c_cap[j].cyc != c_cap[j - 1].cyc + 1) nb++;
      chk("cont_bad_lines", bad, 0);
      chk("cont_bubbles", nb, 0);
      chk("cont_seq_4095", c_cap[4095 * per].data[59:48], 12'hFFF);
      chk("cont_seq_wrap", c_cap[4096 * per].data[59:48], 12'h000);
    end

`ifdef CHDR_PKT_GEN_TIMESTAMP_EN
    // Timestamped headers: has_time, length 32 bytes, TIME lines four cycles apart
    wr(1'b0, 8'd4, 32'd1);
    wr(1'b0, 8'd5, 32'd2);
    wr(1'b0, 8'd2, 32'd2);
    wr(1'b0, 8'd3, 32'd0);
    wr(1'b0, 8'd1, 32'd2);
    cap.delete();
    wr(1'b0, 8'd0, 32'd1);
    wait_idle(50, "ts_busy_falls");
    chk("ts_lines", cap.size(), 8);
    if (cap.size() == 8) begin
      chk("ts_has_time", cap[0].data[61], 1'b1);
      chk("ts_length", cap[0].data[47:32], 16'h0020);
      chk("ts_delta", cap[5].data - cap[1].data, 64'd4);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
